// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display: digit count, blank
// pattern, active-low glyphs ({g,f,e,d,c,b,a}) and the per-slot scan state.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD nibble to active-low 7-segment pattern; non-decimal codes A-F show blank.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        seg_n = SEG_BLANK;
        case (nibble)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed 7-segment scanner with ghosting blank per slot and a
// frame-aligned shadow load. Optional macro: LEADING_ZERO_SUPPRESS_EN.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [4*NUM_DIGITS-1:0]   digit_data,
    input  logic                      load_req,
    output logic                      load_ack,
    output logic [1:0]                digit_sel,
    output logic [NUM_DIGITS-1:0]     anode_n,
    output logic [6:0]                seg_n,
    output logic                      frame_start
);

    localparam int            PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);

    logic [PW-1:0]           prescaler;
    scan_state_t             state_q, state_d;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    pending;
    logic                    terminal;
    logic                    load_fire;
    logic [3:0]              cur_nibble;
    logic [6:0]              cur_seg;
    logic                    suppress;
    logic [NUM_DIGITS-1:0]   anode_d;
    logic [6:0]              seg_d;

    assign terminal = enable && (prescaler == PRE_LAST);

    // While scanning, the shadow only changes at the end of digit 3 so a frame
    // never mixes old and new digits; while idle, loads are served at once.
    assign load_fire = (pending || load_req) &&
                       (!enable || (terminal && digit_sel == 2'd3));

    always_comb begin
        state_d = state_q;
        if (!enable || terminal) begin
            state_d = ST_BLANK;
        end else if (prescaler == BLANK_LAST) begin
            state_d = ST_SHOW;
        end
    end

    assign cur_nibble = shadow[{digit_sel, 2'b00} +: 4];

    bcd_to_7seg u_decode (
        .nibble (cur_nibble),
        .seg_n  (cur_seg)
    );

`ifdef LEADING_ZERO_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] zero_nib;

    assign zero_nib = {shadow[15:12] == 4'd0, shadow[11:8] == 4'd0,
                       shadow[7:4]   == 4'd0, shadow[3:0]  == 4'd0};

    always_comb begin
        suppress = 1'b0;
        case (digit_sel)
            2'd3:    suppress = zero_nib[3];
            2'd2:    suppress = &zero_nib[3:2];
            2'd1:    suppress = &zero_nib[3:1];
            default: suppress = 1'b0;
        endcase
    end
`else
    assign suppress = 1'b0;
`endif

    // Gating with enable makes the display go dark on the first idle cycle.
    always_comb begin
        anode_d = 4'hF;
        seg_d   = SEG_BLANK;
        if (enable && state_q == ST_SHOW) begin
            anode_d = ~(4'b0001 << digit_sel);
            seg_d   = suppress ? SEG_BLANK : cur_seg;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler   <= '0;
            digit_sel   <= 2'd0;
            state_q     <= ST_BLANK;
            shadow      <= '0;
            pending     <= 1'b0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
            anode_n     <= 4'hF;
            seg_n       <= SEG_BLANK;
        end else begin
            if (!enable || terminal) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            if (terminal) begin
                digit_sel <= digit_sel + 1'b1;
            end
            state_q <= state_d;
            if (load_fire) begin
                shadow <= digit_data;
            end
            pending     <= (pending || load_req) && !load_fire;
            load_ack    <= load_fire;
            frame_start <= terminal && (digit_sel == 2'd3);
            anode_n     <= anode_d;
            seg_n       <= seg_d;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with REFRESH_DIV=8, BLANK_CYCLES=2;
// expectations follow LEADING_ZERO_SUPPRESS_EN when it is defined.
module tb_display_scan_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] digit_data;
    logic        load_req;
    logic        load_ack;
    logic [1:0]  digit_sel;
    logic [3:0]  anode_n;
    logic [6:0]  seg_n;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

`ifdef LEADING_ZERO_SUPPRESS_EN
    localparam logic [6:0] LEAD_ZERO = 7'h7F;
`else
    localparam logic [6:0] LEAD_ZERO = 7'h40;
`endif

    always #5 clk = ~clk;

    display_scan_controller #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .digit_data  (digit_data),
        .load_req    (load_req),
        .load_ack    (load_ack),
        .digit_sel   (digit_sel),
        .anode_n     (anode_n),
        .seg_n       (seg_n),
        .frame_start (frame_start)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Waits for a blank gap, then for digit dig's anode; checks its glyph and that it stays lit 6 cycles.
    task automatic check_slot(input logic [1:0] dig, input logic [6:0] exp_seg, input string name);
        logic [3:0] target;
        int         n;
        bit         ok;
        target = ~(4'b0001 << dig);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (anode_n === 4'hF) begin ok = 1; break; end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s blank_gap: anode_n=%h never reached F", name, anode_n);
            return;
        end
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (anode_n === target) begin ok = 1; break; end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s anode_wait: anode_n=%h never reached %h", name, anode_n, target);
            return;
        end
        checks++;
        if (seg_n !== exp_seg) begin
            errors++;
            $display("FAIL %s seg_n: got %h want %h", name, seg_n, exp_seg);
        end
        n = 0;
        while (anode_n === target && n < 12) begin
            n++;
            tick();
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL %s lit_cycles: got %0d want 6", name, n);
        end
    endtask

    // Loads data while idle (enable=0); the ack must follow on the next cycle only.
    task automatic load_idle(input logic [15:0] data);
        enable     = 1'b0;
        digit_data = data;
        load_req   = 1'b1;
        tick();
        load_req = 1'b0;
        checks++;
        if (load_ack !== 1'b1) begin
            errors++;
            $display("FAIL idle_load_ack: got %b want 1", load_ack);
        end
        tick();
        checks++;
        if (load_ack !== 1'b0) begin
            errors++;
            $display("FAIL idle_load_ack_pulse: got %b want 0", load_ack);
        end
    endtask

    task automatic wait_for(input logic [1:0] ds, input logic [3:0] an, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (digit_sel === ds && anode_n === an) begin ok = 1; break; end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s wait: digit_sel=%0d anode_n=%h", name, digit_sel, anode_n);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        load_req   = 1'b0;
        digit_data = 16'h0000;
        tick();
        tick();
        checks += 5;
        if (anode_n !== 4'hF)    begin errors++; $display("FAIL reset_anode: got %h want F", anode_n); end
        if (seg_n !== 7'h7F)     begin errors++; $display("FAIL reset_seg: got %h want 7F", seg_n); end
        if (digit_sel !== 2'd0)  begin errors++; $display("FAIL reset_digit_sel: got %0d want 0", digit_sel); end
        if (load_ack !== 1'b0)   begin errors++; $display("FAIL reset_load_ack: got %b want 0", load_ack); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
        reset = 1'b0;
    endtask

    task automatic test_scan_1234();
        int n;
        enable     = 1'b1;
        digit_data = 16'h1234;
        load_req   = 1'b1;
        tick();
        load_req = 1'b0;
        n = 1;
        while (load_ack !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks += 3;
        if (n != 32)              begin errors++; $display("FAIL scan_ack_latency: got %0d want 32", n); end
        if (frame_start !== 1'b1) begin errors++; $display("FAIL scan_frame_start: got %b want 1", frame_start); end
        if (digit_sel !== 2'd0)   begin errors++; $display("FAIL scan_wrap_digit_sel: got %0d want 0", digit_sel); end
        check_slot(2'd0, 7'h19, "scan_d0");
        check_slot(2'd1, 7'h30, "scan_d1");
        check_slot(2'd2, 7'h24, "scan_d2");
        check_slot(2'd3, 7'h79, "scan_d3");
    endtask

    task automatic test_load_midframe();
        logic [15:0] old_data;
        int          acks;
        int          d;
        bit          seen3;
        logic [1:0]  ack_ds;
        logic        ack_fs;
        old_data = 16'h1234;
        acks     = 0;
        seen3    = 0;
        ack_ds   = 2'd3;
        ack_fs   = 1'b0;
        wait_for(2'd1, 4'hD, "mid_start");
        digit_data = 16'h5678;
        for (int i = 0; i < 80; i++) begin
            load_req = (i < 3);
            tick();
            if (load_ack === 1'b1) begin
                if (acks == 0) begin
                    ack_ds = digit_sel;
                    ack_fs = frame_start;
                end
                acks++;
            end else if (acks == 0) begin
                if (digit_sel === 2'd3) seen3 = 1;
                case (anode_n)
                    4'hE: d = 0;
                    4'hD: d = 1;
                    4'hB: d = 2;
                    4'h7: d = 3;
                    default: d = -1;
                endcase
                if (d >= 0) begin
                    checks++;
                    if (seg_n !== glyph(old_data[4*d +: 4])) begin
                        errors++;
                        $display("FAIL mid_old_glyph d%0d: got %h want %h", d, seg_n, glyph(old_data[4*d +: 4]));
                    end
                end
            end
        end
        load_req = 1'b0;
        checks += 4;
        if (acks != 1)        begin errors++; $display("FAIL mid_single_ack: got %0d acks want 1", acks); end
        if (!seen3)           begin errors++; $display("FAIL mid_ack_early: ack before digit 3 was scanned"); end
        if (ack_ds !== 2'd0)  begin errors++; $display("FAIL mid_ack_digit_sel: got %0d want 0", ack_ds); end
        if (ack_fs !== 1'b1)  begin errors++; $display("FAIL mid_ack_frame_start: got %b want 1", ack_fs); end
        check_slot(2'd0, 7'h00, "mid_d0");
        check_slot(2'd1, 7'h78, "mid_d1");
        check_slot(2'd2, 7'h02, "mid_d2");
        check_slot(2'd3, 7'h12, "mid_d3");
    endtask

    task automatic test_latch_cycle();
        int acks;
        wait_for(2'd3, 4'h7, "latch_start");
        for (int i = 0; i < 4; i++) tick();
        checks += 2;
        if (load_ack !== 1'b0)  begin errors++; $display("FAIL latch_pre_ack: got %b want 0", load_ack); end
        if (digit_sel !== 2'd3) begin errors++; $display("FAIL latch_pre_digit_sel: got %0d want 3", digit_sel); end
        digit_data = 16'h2468;
        load_req   = 1'b1;
        tick();
        load_req = 1'b0;
        checks += 3;
        if (load_ack !== 1'b1)    begin errors++; $display("FAIL latch_same_cycle_ack: got %b want 1", load_ack); end
        if (frame_start !== 1'b1) begin errors++; $display("FAIL latch_frame_start: got %b want 1", frame_start); end
        if (digit_sel !== 2'd0)   begin errors++; $display("FAIL latch_digit_sel: got %0d want 0", digit_sel); end
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (load_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL latch_extra_ack: got %0d want 0", acks); end
        check_slot(2'd3, 7'h24, "latch_d3");
        check_slot(2'd0, 7'h00, "latch_d0");
    endtask

    task automatic test_char_blank();
        load_idle(16'h00A1);
        enable = 1'b1;
        check_slot(2'd1, 7'h7F, "hex_d1");
        check_slot(2'd3, LEAD_ZERO, "hex_d3");
        check_slot(2'd0, 7'h79, "hex_d0");
    endtask

    task automatic test_leading_zero();
        load_idle(16'h0042);
        enable = 1'b1;
        check_slot(2'd2, LEAD_ZERO, "lz42_d2");
        check_slot(2'd3, LEAD_ZERO, "lz42_d3");
        check_slot(2'd0, 7'h24, "lz42_d0");
        check_slot(2'd1, 7'h19, "lz42_d1");
        load_idle(16'h0000);
        enable = 1'b1;
        check_slot(2'd0, 7'h40, "lz00_d0");
        check_slot(2'd1, LEAD_ZERO, "lz00_d1");
        check_slot(2'd3, LEAD_ZERO, "lz00_d3");
    endtask

    task automatic test_disable();
        enable = 1'b1;
        wait_for(2'd2, 4'hB, "dis_start");
        enable = 1'b0;
        tick();
        checks += 2;
        if (anode_n !== 4'hF)   begin errors++; $display("FAIL dis_anode_off: got %h want F", anode_n); end
        if (digit_sel !== 2'd2) begin errors++; $display("FAIL dis_digit_sel: got %0d want 2", digit_sel); end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (digit_sel !== 2'd2) begin errors++; $display("FAIL dis_digit_sel_hold: got %0d want 2", digit_sel); end
        load_idle(16'h4321);
        enable = 1'b1;
        tick();
        checks++;
        if (anode_n !== 4'hF) begin errors++; $display("FAIL dis_resume_blank1: got %h want F", anode_n); end
        tick();
        checks++;
        if (anode_n !== 4'hF) begin errors++; $display("FAIL dis_resume_blank2: got %h want F", anode_n); end
        tick();
        checks += 3;
        if (anode_n !== 4'hB)   begin errors++; $display("FAIL dis_resume_show: got %h want B", anode_n); end
        if (seg_n !== 7'h30)    begin errors++; $display("FAIL dis_resume_seg: got %h want 30", seg_n); end
        if (digit_sel !== 2'd2) begin errors++; $display("FAIL dis_resume_digit_sel: got %0d want 2", digit_sel); end
    endtask

    task automatic test_reset_mid_show();
        int acks;
        enable = 1'b1;
        wait_for(2'd1, 4'hD, "rst_start");
        digit_data = 16'h9999;
        load_req   = 1'b1;
        tick();
        load_req = 1'b0;
        checks++;
        if (load_ack !== 1'b0) begin errors++; $display("FAIL rst_pre_ack: got %b want 0", load_ack); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks += 5;
        if (anode_n !== 4'hF)     begin errors++; $display("FAIL rst_mid_anode: got %h want F", anode_n); end
        if (seg_n !== 7'h7F)      begin errors++; $display("FAIL rst_mid_seg: got %h want 7F", seg_n); end
        if (digit_sel !== 2'd0)   begin errors++; $display("FAIL rst_mid_digit_sel: got %0d want 0", digit_sel); end
        if (load_ack !== 1'b0)    begin errors++; $display("FAIL rst_mid_load_ack: got %b want 0", load_ack); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_mid_frame_start: got %b want 0", frame_start); end
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (load_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL rst_pending_discard: got %0d acks want 0", acks); end
        check_slot(2'd0, 7'h40, "rst_d0");
        check_slot(2'd1, LEAD_ZERO, "rst_d1");
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_load_midframe();
        test_latch_cycle();
        test_char_blank();
        test_leading_zero();
        test_disable();
        test_reset_mid_show();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
